// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between two requesters.
// A request is arbitrated (round-robin or fixed priority), and the winner's
// operands are latched. The ALU evaluates them in EXEC. The registered result
// is then held on a response channel, tagged with the owning requester.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid and ready are both high. ready may depend combinationally
// on valid. A producer keeps valid and payload stable until the transfer.
// rsp_valid never depends on rsp_ready.
module alu_arbiter #(
   parameter int unsigned FIXED_PRIO = 0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [31:0]      r0_in1,
   input  logic [31:0]      r0_in2,
   input  logic [3:0]       r0_ctrl,
   input  logic             r0_diff,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [31:0]      r1_in1,
   input  logic [31:0]      r1_in2,
   input  logic [3:0]       r1_ctrl,
   input  logic             r1_diff,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [31:0]      rsp_out,
   output logic             rsp_zero,
   output logic             busy,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_last_grant;
   logic [31:0]      r_in1;
   logic [31:0]      r_in2;
   logic [3:0]       r_ctrl;
   logic             r_diff;
   logic             r_id;
   logic [31:0]      r_rsp_out;
   logic             r_rsp_zero;
   logic             r_rsp_id;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   logic             w_arb_en;
   logic             w_pick1;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_grant;
   logic [4:0]       w_shamt;
   logic [31:0]      w_alu_out;

   // Arbitration: only in IDLE, or in RESP when the result is being consumed.
   always_comb begin
      w_arb_en = (r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready);
      w_pick1  = 1'b0;
      if (r0_valid && r1_valid) begin
         // last_grant=1 means requester 0 wins the next tie.
         w_pick1 = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
      end else begin
         w_pick1 = r1_valid;
      end
      w_gnt0  = w_arb_en && r0_valid && !w_pick1;
      w_gnt1  = w_arb_en && r1_valid && w_pick1;
      w_grant = w_gnt0 || w_gnt1;
   end

   // Next-state logic for the IDLE -> EXEC -> RESP transaction cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_grant) w_state_nxt = S_EXEC;
         S_EXEC: w_state_nxt = S_RESP;
         S_RESP: begin
            if (rsp_ready) w_state_nxt = w_grant ? S_EXEC : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Latch the winner's operands and remember who won at the grant edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in1        <= '0;
         r_in2        <= '0;
         r_ctrl       <= '0;
         r_diff       <= 1'b0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_grant) begin
         r_in1        <= w_gnt1 ? r1_in1  : r0_in1;
         r_in2        <= w_gnt1 ? r1_in2  : r0_in2;
         r_ctrl       <= w_gnt1 ? r1_ctrl : r0_ctrl;
         r_diff       <= w_gnt1 ? r1_diff : r0_diff;
         r_id         <= w_gnt1;
         r_last_grant <= w_gnt1;
      end
   end

   // ALU: R-type full decode when diff=0, I-type funct3 decode when diff=1.
   always_comb begin
      w_shamt   = r_in2[4:0];
      w_alu_out = '0;
      if (r_diff) begin
         case (r_ctrl[2:0])
            3'b000: w_alu_out = r_in1 + r_in2;
            3'b001: w_alu_out = r_in1 << w_shamt;
            3'b010: w_alu_out = {31'd0, $signed(r_in1) < $signed(r_in2)};
            3'b011: w_alu_out = {31'd0, r_in1 < r_in2};
            3'b100: w_alu_out = r_in1 ^ r_in2;
            3'b101: w_alu_out = r_ctrl[3] ? $unsigned($signed(r_in1) >>> w_shamt)
                                          : (r_in1 >> w_shamt);
            3'b110: w_alu_out = r_in1 | r_in2;
            default: w_alu_out = r_in1 & r_in2;
         endcase
      end else begin
         case (r_ctrl)
            4'b0000: w_alu_out = r_in1 + r_in2;
            4'b1000: w_alu_out = r_in1 - r_in2;
            4'b0001: w_alu_out = r_in1 << w_shamt;
            4'b0010: w_alu_out = {31'd0, $signed(r_in1) < $signed(r_in2)};
            4'b0011: w_alu_out = {31'd0, r_in1 < r_in2};
            4'b0100: w_alu_out = r_in1 ^ r_in2;
            4'b0101: w_alu_out = r_in1 >> w_shamt;
            4'b1101: w_alu_out = $unsigned($signed(r_in1) >>> w_shamt);
            4'b0110: w_alu_out = r_in1 | r_in2;
            4'b0111: w_alu_out = r_in1 & r_in2;
            default: w_alu_out = '0;
         endcase
      end
   end

   // Capture the ALU result in EXEC; it then holds through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_out  <= '0;
         r_rsp_zero <= 1'b0;
         r_rsp_id   <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_rsp_out  <= w_alu_out;
         r_rsp_zero <= (w_alu_out == 32'd0);
         r_rsp_id   <= r_id;
      end
   end

   // Saturating grant counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (cnt_clr) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_gnt0 && (r_cnt0 != CNT_MAX)) r_cnt0 <= r_cnt0 + CNT_ONE;
         if (w_gnt1 && (r_cnt1 != CNT_MAX)) r_cnt1 <= r_cnt1 + CNT_ONE;
      end
   end

   assign r0_ready  = w_gnt0;
   assign r1_ready  = w_gnt1;
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_id    = r_rsp_id;
   assign rsp_out   = r_rsp_out;
   assign rsp_zero  = r_rsp_zero;
   assign busy      = (r_state != S_IDLE);
   assign cnt0      = r_cnt0;
   assign cnt1      = r_cnt1;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance a is round-robin with 16-bit counters,
// instance b is fixed-priority with 2-bit counters. Both share the stimulus.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_valid, r1_valid;
   logic [31:0] r0_in1, r0_in2, r1_in1, r1_in2;
   logic [3:0]  r0_ctrl, r1_ctrl;
   logic        r0_diff, r1_diff;
   logic        rsp_ready, cnt_clr;

   logic        a_r0_ready, a_r1_ready, a_rsp_valid, a_rsp_id, a_rsp_zero, a_busy;
   logic [31:0] a_rsp_out;
   logic [15:0] a_cnt0, a_cnt1;
   logic [1:0]  a_dbg;
   logic        b_r0_ready, b_r1_ready, b_rsp_valid, b_rsp_id, b_rsp_zero, b_busy;
   logic [31:0] b_rsp_out;
   logic [1:0]  b_cnt0, b_cnt1;
   logic [1:0]  b_dbg;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [33:0] exp_q[$];
   int          gseq[$];
   bit          g0, g1;
   logic [3:0]  legal_codes [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                     4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   alu_arbiter #(.FIXED_PRIO(0), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(a_r0_ready), .r0_in1(r0_in1), .r0_in2(r0_in2),
      .r0_ctrl(r0_ctrl), .r0_diff(r0_diff),
      .r1_valid(r1_valid), .r1_ready(a_r1_ready), .r1_in1(r1_in1), .r1_in2(r1_in2),
      .r1_ctrl(r1_ctrl), .r1_diff(r1_diff),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(a_rsp_id),
      .rsp_out(a_rsp_out), .rsp_zero(a_rsp_zero), .busy(a_busy),
      .cnt_clr(cnt_clr), .cnt0(a_cnt0), .cnt1(a_cnt1), .dbg_state(a_dbg)
   );

   alu_arbiter #(.FIXED_PRIO(1), .CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(b_r0_ready), .r0_in1(r0_in1), .r0_in2(r0_in2),
      .r0_ctrl(r0_ctrl), .r0_diff(r0_diff),
      .r1_valid(r1_valid), .r1_ready(b_r1_ready), .r1_in1(r1_in1), .r1_in2(r1_in2),
      .r1_ctrl(r1_ctrl), .r1_diff(r1_diff),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(b_rsp_id),
      .rsp_out(b_rsp_out), .rsp_zero(b_rsp_zero), .busy(b_busy),
      .cnt_clr(cnt_clr), .cnt0(b_cnt0), .cnt1(b_cnt1), .dbg_state(b_dbg)
   );

   // Reference ALU written from the instruction-set definitions.
   function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                           input logic [3:0] c, input logic d);
      logic [4:0] s;
      s = y[4:0];
      if (d) begin
         case (c[2:0])
            3'd0: return x + y;
            3'd1: return x << s;
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return c[3] ? $unsigned($signed(x) >>> s) : (x >> s);
            3'd6: return x | y;
            default: return x & y;
         endcase
      end
      case (c)
         4'b0000: return x + y;
         4'b1000: return x - y;
         4'b0001: return x << s;
         4'b0010: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'b0011: return (x < y) ? 32'd1 : 32'd0;
         4'b0100: return x ^ y;
         4'b0101: return x >> s;
         4'b1101: return $unsigned($signed(x) >>> s);
         4'b0110: return x | y;
         4'b0111: return x & y;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [33:0] exp_of(input logic id, input logic [31:0] x,
                                          input logic [31:0] y, input logic [3:0] c,
                                          input logic d);
      logic [31:0] r;
      r = alu_ref(x, y, c, d);
      return {id, (r == 32'd0), r};
   endfunction

   // One comparison point.
   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Observe the current cycle (scoreboard push/pop), then advance one clock.
   task automatic tick(input bit fp);
      logic        rdy0, rdy1, vld;
      logic [33:0] obs, e;
      rdy0 = fp ? b_r0_ready : a_r0_ready;
      rdy1 = fp ? b_r1_ready : a_r1_ready;
      vld  = fp ? b_rsp_valid : a_rsp_valid;
      obs  = fp ? {b_rsp_id, b_rsp_zero, b_rsp_out} : {a_rsp_id, a_rsp_zero, a_rsp_out};
      chk("one_ready", 34'(rdy0 & rdy1), 34'd0);
      g0 = r0_valid && rdy0;
      g1 = r1_valid && rdy1;
      if (vld && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 34'(vld), 34'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp", obs, e);
         end
      end
      if (g0) begin
         exp_q.push_back(exp_of(1'b0, r0_in1, r0_in2, r0_ctrl, r0_diff));
         gseq.push_back(0);
      end
      if (g1) begin
         exp_q.push_back(exp_of(1'b1, r1_in1, r1_in2, r1_ctrl, r1_diff));
         gseq.push_back(1);
      end
      @(posedge clk);
      #1;
   endtask

   // Driver tasks.
   task automatic set_r0(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] c, input logic d);
      r0_valid = v; r0_in1 = x; r0_in2 = y; r0_ctrl = c; r0_diff = d;
   endtask

   task automatic set_r1(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] c, input logic d);
      r1_valid = v; r1_in1 = x; r1_in2 = y; r1_ctrl = c; r1_diff = d;
   endtask

   task automatic rand_r0();
      logic d;
      d = 1'($urandom_range(0, 1));
      set_r0(1'b1, $urandom, $urandom,
             d ? 4'($urandom_range(0, 15)) : legal_codes[$urandom_range(0, 9)], d);
   endtask

   task automatic rand_r1();
      logic d;
      d = 1'($urandom_range(0, 1));
      set_r1(1'b1, $urandom, $urandom,
             d ? 4'($urandom_range(0, 15)) : legal_codes[$urandom_range(0, 9)], d);
   endtask

   // Issue one request and wait (bounded) for its grant.
   task automatic send(input bit fp, input bit id, input logic [31:0] x,
                       input logic [31:0] y, input logic [3:0] c, input logic d);
      bit done;
      done = 1'b0;
      if (id) set_r1(1'b1, x, y, c, d);
      else    set_r0(1'b1, x, y, c, d);
      #1;
      for (int k = 0; k < 10 && !done; k++) begin
         tick(fp);
         done = id ? g1 : g0;
      end
      chk("grant_timeout", 34'(done), 34'd1);
      if (id) r1_valid = 1'b0;
      else    r0_valid = 1'b0;
      #1;
   endtask

   task automatic drain(input bit fp);
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick(fp);
      chk("drain", 34'(exp_q.size()), 34'd0);
      tick(fp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      r0_valid = 1'b0; r1_valid = 1'b0; cnt_clr = 1'b0; rsp_ready = 1'b1;
      exp_q.delete();
      gseq.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   logic [33:0] hold;

   initial begin
      // Reset state.
      rst_n = 1'b0; rsp_ready = 1'b0; cnt_clr = 1'b0;
      set_r0(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
      set_r1(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
      #3;
      chk("rst_a_rsp", {a_rsp_id, a_rsp_zero, a_rsp_out}, 34'd0);
      chk("rst_a_flags", 34'({a_rsp_valid, a_busy, a_dbg}), 34'd0);
      chk("rst_a_cnt", 34'({a_cnt0, a_cnt1}), 34'd0);
      chk("rst_b_rsp", {b_rsp_id, b_rsp_zero, b_rsp_out}, 34'd0);
      chk("rst_b_flags", 34'({b_rsp_valid, b_busy, b_dbg, b_cnt0, b_cnt1}), 34'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      #1;

      // R0 ADD 5+7, checking 2-cycle latency.
      set_r0(1'b1, 32'd5, 32'd7, 4'b0000, 1'b0);
      #1;
      chk("t1_r0_ready", 34'(a_r0_ready), 34'd1);
      tick(0);
      r0_valid = 1'b0;
      #1;
      chk("t1_exec_valid", 34'(a_rsp_valid), 34'd0);
      chk("t1_exec_state", 34'({a_busy, a_dbg}), 34'({1'b1, 2'd1}));
      tick(0);
      chk("t1_rsp", {a_rsp_valid, a_rsp_id, a_rsp_zero, a_rsp_out}, {1'b1, 1'b0, 1'b0, 32'd12});
      drain(0);
      chk("t1_idle", 34'({a_rsp_valid, a_busy}), 34'd0);

      // R1 SUB giving zero, then SRAI of a negative value.
      send(0, 1'b1, 32'd3, 32'd3, 4'b1000, 1'b0);
      tick(0);
      chk("t2_sub", {a_rsp_id, a_rsp_zero, a_rsp_out}, {1'b1, 1'b1, 32'd0});
      drain(0);
      send(0, 1'b1, 32'h8000_0000, 32'd4, 4'b1101, 1'b1);
      tick(0);
      chk("t2_srai", {a_rsp_id, a_rsp_zero, a_rsp_out}, {1'b1, 1'b0, 32'hF800_0000});
      drain(0);

      // Round-robin with both requesters always valid.
      do_reset();
      rand_r0();
      rand_r1();
      #1;
      for (int k = 0; k < 40 && gseq.size() < 4; k++) begin
         tick(0);
         if (g0) rand_r0();
         if (g1) rand_r1();
         #1;
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      #1;
      drain(0);
      chk("rr_ngrants", 34'(gseq.size()), 34'd4);
      for (int i = 0; i < 4 && i < gseq.size(); i++) chk("rr_order", 34'(gseq[i]), 34'(i % 2));
      chk("rr_cnt", 34'({a_cnt0, a_cnt1}), 34'({16'd2, 16'd2}));

      // Fixed priority on instance b: requester 0 takes every tie.
      do_reset();
      rand_r0();
      rand_r1();
      #1;
      for (int k = 0; k < 40 && gseq.size() < 4; k++) begin
         tick(1);
         if (g0) rand_r0();
         if (g1) rand_r1();
         #1;
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      #1;
      drain(1);
      chk("fp_ngrants", 34'(gseq.size()), 34'd4);
      for (int i = 0; i < gseq.size(); i++) chk("fp_winner", 34'(gseq[i]), 34'd0);
      chk("fp_cnt_sat4", 34'({b_cnt0, b_cnt1}), 34'({2'd3, 2'd0}));
      send(1, 1'b0, 32'd1, 32'd2, 4'b0110, 1'b0);
      drain(1);
      chk("fp_cnt_sat5", 34'(b_cnt0), 34'd3);
      r0_valid = 1'b1;
      cnt_clr = 1'b1;
      #1;
      tick(1);
      chk("clr_grant", 34'(g0), 34'd1);
      r0_valid = 1'b0;
      cnt_clr = 1'b0;
      #1;
      chk("clr_wins", 34'(b_cnt0), 34'd0);
      drain(1);

      // Backpressure: result held, r1 blocked, then granted as rsp_ready rises.
      do_reset();
      rsp_ready = 1'b0;
      rand_r0();
      #1;
      tick(0);
      chk("bp_grant0", 34'(g0), 34'd1);
      r0_valid = 1'b0;
      rand_r1();
      #1;
      chk("bp_exec_r1", 34'(a_r1_ready), 34'd0);
      tick(0);
      hold = exp_q[0];
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 34'(a_rsp_valid), 34'd1);
         chk("bp_hold", {a_rsp_id, a_rsp_zero, a_rsp_out}, hold);
         chk("bp_r1_blocked", 34'(a_r1_ready), 34'd0);
         tick(0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_r1_same_cycle", 34'(a_r1_ready), 34'd1);
      tick(0);
      r1_valid = 1'b0;
      #1;
      drain(0);

      // Reset asserted during EXEC discards the transaction.
      send(0, 1'b0, 32'd9, 32'd1, 4'b0000, 1'b0);
      chk("mr_in_exec", 34'(a_dbg), 34'd1);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mr_state", 34'({a_rsp_valid, a_busy, a_cnt0, a_cnt1}), 34'd0);
      tick(0);
      tick(0);
      chk("mr_no_rsp", 34'(a_rsp_valid), 34'd0);
      rst_n = 1'b1;
      #1;
      send(0, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 4'b0110, 1'b0);
      tick(0);
      chk("mr_next", {a_rsp_valid, a_rsp_id, a_rsp_out}, {1'b1, 1'b1, 32'hFFFF_FFFF});
      drain(0);
      chk("mr_cnt", 34'({a_cnt0, a_cnt1}), 34'({16'd0, 16'd1}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
